sirv_qspi_flash_rdmap: RTL and testbench



---
 rtl/sirv_qspi_pkg.sv | 22 ++
 rtl/sirv_qspi_flash_rdmap.sv | 224 ++++++++++++++++++++++
 tb/tb_sirv_qspi_flash_rdmap.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sirv_qspi_pkg.sv
// Shared definitions for the QSPI flash read sequencer: protocol codes,
// sequencer state encoding and link direction values.
package sirv_qspi_pkg;

   localparam logic [1:0] QSPI_PROTO_SINGLE = 2'd0;
   localparam logic [1:0] QSPI_PROTO_DUAL   = 2'd1;
   localparam logic [1:0] QSPI_PROTO_QUAD   = 2'd2;

   localparam logic DIR_TX = 1'b1;
   localparam logic DIR_RX = 1'b0;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_CMD     = 3'd1,
      ST_ADDR    = 3'd2,
      ST_PAD     = 3'd3,
      ST_DATA    = 3'd4,
      ST_WAIT_RX = 3'd5,
      ST_RESP    = 3'd6
   } rdmap_state_e;

endpackage

// File: rtl/sirv_qspi_flash_rdmap.sv
// Byte-read sequencer in front of the QSPI media stage: emits cmd/addr/pad/data
// link transfers per request and merges sequential reads into one CS burst.
module sirv_qspi_flash_rdmap
   import sirv_qspi_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        io_en,
   input  logic        io_insn_cmd_en,
   input  logic [7:0]  io_insn_cmd_code,
   input  logic [1:0]  io_insn_cmd_proto,
   input  logic [2:0]  io_insn_addr_len,
   input  logic [1:0]  io_insn_addr_proto,
   input  logic [3:0]  io_insn_pad_cnt,
   input  logic [7:0]  io_insn_pad_code,
   input  logic [1:0]  io_insn_data_proto,
   output logic        io_addr_ready,
   input  logic        io_addr_valid,
   input  logic [31:0] io_addr_bits,
   input  logic        io_data_ready,
   output logic        io_data_valid,
   output logic [7:0]  io_data_bits,
   input  logic        io_link_tx_ready,
   output logic        io_link_tx_valid,
   output logic [7:0]  io_link_tx_bits,
   input  logic        io_link_rx_valid,
   input  logic [7:0]  io_link_rx_bits,
   output logic [7:0]  io_link_cnt,
   output logic [1:0]  io_link_fmt_proto,
   output logic        io_link_fmt_endian,
   output logic        io_link_fmt_iodir,
   output logic        io_link_cs_set,
   output logic        io_link_cs_clear,
   output logic        io_link_cs_hold,
   input  logic        io_link_active
);

   rdmap_state_e state_reg, state_next;

   logic [31:0] addr_reg;
   logic [31:0] next_addr_reg;
   logic        merge_ok_reg;
   logic        restart_reg;
   logic [2:0]  byte_cnt_reg, byte_cnt_next;
   logic [7:0]  data_reg;

   logic        cmd_en_reg;
   logic [7:0]  cmd_code_reg;
   logic [1:0]  cmd_proto_reg;
   logic [2:0]  addr_len_reg;
   logic [1:0]  addr_proto_reg;
   logic [3:0]  pad_cnt_reg;
   logic [7:0]  pad_code_reg;
   logic [1:0]  data_proto_reg;

   logic        accept;
   logic        tx_hs;
   logic        merge_hit;
   logic [2:0]  addr_len_clamped;
   logic [7:0]  addr_byte;

   // First phase following the command (or the start, when no command is sent).
   function automatic rdmap_state_e phase_after_cmd(input logic [2:0] len, input logic [3:0] pad);
      if (len != 3'd0)
         return ST_ADDR;
      else if (pad != 4'd0)
         return ST_PAD;
      else
         return ST_DATA;
   endfunction

   assign addr_len_clamped = (io_insn_addr_len > 3'd4) ? 3'd4 : io_insn_addr_len;
   assign accept    = io_addr_ready & io_addr_valid;
   assign tx_hs     = io_link_tx_valid & io_link_tx_ready;
   assign merge_hit = merge_ok_reg & io_link_active & (io_addr_bits == next_addr_reg);

   // byte_cnt counts remaining address bytes, so it selects the MSB-first byte directly.
   always_comb begin
      case (byte_cnt_reg)
         3'd4:    addr_byte = addr_reg[31:24];
         3'd3:    addr_byte = addr_reg[23:16];
         3'd2:    addr_byte = addr_reg[15:8];
         default: addr_byte = addr_reg[7:0];
      endcase
   end

   always_comb begin
      state_next        = state_reg;
      byte_cnt_next     = byte_cnt_reg;
      io_addr_ready     = 1'b0;
      io_data_valid     = 1'b0;
      io_link_tx_valid  = 1'b0;
      io_link_tx_bits   = 8'h00;
      io_link_cnt       = 8'd0;
      io_link_fmt_proto = QSPI_PROTO_SINGLE;
      io_link_fmt_iodir = DIR_RX;

      case (state_reg)
         ST_IDLE: begin
            io_addr_ready = io_en;
            if (accept) begin
               byte_cnt_next = addr_len_clamped;
               if (merge_hit)
                  state_next = ST_DATA;
               else if (io_insn_cmd_en)
                  state_next = ST_CMD;
               else
                  state_next = phase_after_cmd(addr_len_clamped, io_insn_pad_cnt);
            end
         end
         ST_CMD: begin
            io_link_tx_valid  = 1'b1;
            io_link_tx_bits   = cmd_code_reg;
            io_link_cnt       = 8'd8;
            io_link_fmt_proto = cmd_proto_reg;
            io_link_fmt_iodir = DIR_TX;
            if (tx_hs)
               state_next = phase_after_cmd(addr_len_reg, pad_cnt_reg);
         end
         ST_ADDR: begin
            io_link_tx_valid  = 1'b1;
            io_link_tx_bits   = addr_byte;
            io_link_cnt       = 8'd8;
            io_link_fmt_proto = addr_proto_reg;
            io_link_fmt_iodir = DIR_TX;
            if (tx_hs) begin
               byte_cnt_next = byte_cnt_reg - 3'd1;
               if (byte_cnt_reg == 3'd1)
                  state_next = (pad_cnt_reg != 4'd0) ? ST_PAD : ST_DATA;
            end
         end
         ST_PAD: begin
            io_link_tx_valid  = 1'b1;
            io_link_tx_bits   = pad_code_reg;
            io_link_cnt       = {4'd0, pad_cnt_reg};
            io_link_fmt_proto = addr_proto_reg;
            io_link_fmt_iodir = DIR_TX;
            if (tx_hs)
               state_next = ST_DATA;
         end
         ST_DATA: begin
            io_link_tx_valid  = 1'b1;
            io_link_cnt       = 8'd8;
            io_link_fmt_proto = data_proto_reg;
            io_link_fmt_iodir = DIR_RX;
            if (tx_hs)
               state_next = ST_WAIT_RX;
         end
         ST_WAIT_RX: begin
            if (io_link_rx_valid)
               state_next = ST_RESP;
         end
         ST_RESP: begin
            io_data_valid = 1'b1;
            if (io_data_ready)
               state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_reg      <= ST_IDLE;
         addr_reg       <= 32'd0;
         next_addr_reg  <= 32'd0;
         merge_ok_reg   <= 1'b0;
         restart_reg    <= 1'b0;
         byte_cnt_reg   <= 3'd0;
         data_reg       <= 8'h00;
         cmd_en_reg     <= 1'b0;
         cmd_code_reg   <= 8'h00;
         cmd_proto_reg  <= 2'd0;
         addr_len_reg   <= 3'd0;
         addr_proto_reg <= 2'd0;
         pad_cnt_reg    <= 4'd0;
         pad_code_reg   <= 8'h00;
         data_proto_reg <= 2'd0;
      end else begin
         state_reg    <= state_next;
         byte_cnt_reg <= byte_cnt_next;

         if (accept) begin
            addr_reg       <= io_addr_bits;
            cmd_en_reg     <= io_insn_cmd_en;
            cmd_code_reg   <= io_insn_cmd_code;
            cmd_proto_reg  <= io_insn_cmd_proto;
            addr_len_reg   <= addr_len_clamped;
            addr_proto_reg <= io_insn_addr_proto;
            pad_cnt_reg    <= io_insn_pad_cnt;
            pad_code_reg   <= io_insn_pad_code;
            data_proto_reg <= io_insn_data_proto;
         end

         // A fresh (non-merged) sequence asks the media to drop CS before its first transfer.
         if (accept && !merge_hit)
            restart_reg <= 1'b1;
         else if (tx_hs)
            restart_reg <= 1'b0;

         // io_en low wins over a simultaneous response handshake.
         if (!io_en)
            merge_ok_reg <= 1'b0;
         else if (state_reg == ST_RESP && io_data_ready)
            merge_ok_reg <= 1'b1;

         if (state_reg == ST_RESP && io_data_ready)
            next_addr_reg <= addr_reg + 32'd1;

         if (state_reg == ST_WAIT_RX && io_link_rx_valid)
            data_reg <= io_link_rx_bits;
      end
   end

   assign io_data_bits       = data_reg;
   assign io_link_cs_clear   = restart_reg;
   assign io_link_fmt_endian = 1'b0;
   assign io_link_cs_set     = 1'b1;
   assign io_link_cs_hold    = 1'b1;

   logic unused_ok;
   assign unused_ok = cmd_en_reg;

endmodule

// File: tb/tb_sirv_qspi_flash_rdmap.sv
// Scoreboard bench for sirv_qspi_flash_rdmap: directed read requests push
// expected link transfers and read bytes; a monitor pops and compares them.
module tb_sirv_qspi_flash_rdmap;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        io_en = 1'b0;
   logic        io_insn_cmd_en = 1'b0;
   logic [7:0]  io_insn_cmd_code = 8'h00;
   logic [1:0]  io_insn_cmd_proto = 2'd0;
   logic [2:0]  io_insn_addr_len = 3'd0;
   logic [1:0]  io_insn_addr_proto = 2'd0;
   logic [3:0]  io_insn_pad_cnt = 4'd0;
   logic [7:0]  io_insn_pad_code = 8'h00;
   logic [1:0]  io_insn_data_proto = 2'd0;
   logic        io_addr_ready;
   logic        io_addr_valid = 1'b0;
   logic [31:0] io_addr_bits = 32'd0;
   logic        io_data_ready = 1'b1;
   logic        io_data_valid;
   logic [7:0]  io_data_bits;
   logic        io_link_tx_ready = 1'b1;
   logic        io_link_tx_valid;
   logic [7:0]  io_link_tx_bits;
   logic        io_link_rx_valid = 1'b0;
   logic [7:0]  io_link_rx_bits = 8'h00;
   logic [7:0]  io_link_cnt;
   logic [1:0]  io_link_fmt_proto;
   logic        io_link_fmt_endian;
   logic        io_link_fmt_iodir;
   logic        io_link_cs_set;
   logic        io_link_cs_clear;
   logic        io_link_cs_hold;
   logic        io_link_active = 1'b1;

   sirv_qspi_flash_rdmap dut (
      .clock(clock), .reset(reset), .io_en(io_en),
      .io_insn_cmd_en(io_insn_cmd_en), .io_insn_cmd_code(io_insn_cmd_code),
      .io_insn_cmd_proto(io_insn_cmd_proto), .io_insn_addr_len(io_insn_addr_len),
      .io_insn_addr_proto(io_insn_addr_proto), .io_insn_pad_cnt(io_insn_pad_cnt),
      .io_insn_pad_code(io_insn_pad_code), .io_insn_data_proto(io_insn_data_proto),
      .io_addr_ready(io_addr_ready), .io_addr_valid(io_addr_valid), .io_addr_bits(io_addr_bits),
      .io_data_ready(io_data_ready), .io_data_valid(io_data_valid), .io_data_bits(io_data_bits),
      .io_link_tx_ready(io_link_tx_ready), .io_link_tx_valid(io_link_tx_valid),
      .io_link_tx_bits(io_link_tx_bits), .io_link_rx_valid(io_link_rx_valid),
      .io_link_rx_bits(io_link_rx_bits), .io_link_cnt(io_link_cnt),
      .io_link_fmt_proto(io_link_fmt_proto), .io_link_fmt_endian(io_link_fmt_endian),
      .io_link_fmt_iodir(io_link_fmt_iodir), .io_link_cs_set(io_link_cs_set),
      .io_link_cs_clear(io_link_cs_clear), .io_link_cs_hold(io_link_cs_hold),
      .io_link_active(io_link_active)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [7:0] bits;
      logic [7:0] cnt;
      logic [1:0] proto;
      logic       iodir;
      logic       csclr;
   } tx_exp_t;

   tx_exp_t    tx_q[$];
   logic [7:0] data_q[$];
   logic [7:0] rx_q[$];

   int checks = 0;
   int errors = 0;
   int tx_hs_cnt = 0;
   int data_done = 0;
   int stall_at = -1;
   int inj_req = 0;
   logic pad_block = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor + media model: compares link/data handshakes, returns rx bytes, shapes tx_ready.
   initial begin
      tx_exp_t     e;
      tx_exp_t     got;
      logic        prev_stall;
      logic [17:0] saved;
      logic [7:0]  d;
      int          rx_cd;
      int          stall_n;
      int          inj_seen;
      logic        stall;
      prev_stall = 1'b0;
      saved = '0;
      rx_cd = 0;
      stall_n = 0;
      inj_seen = 0;
      forever begin
         @(negedge clock);
         if (reset) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall)
               chk("tx_stable", {14'd0, io_link_tx_valid, io_link_tx_bits, io_link_cnt, io_link_fmt_proto},
                   {14'd0, 1'b1, saved});
            prev_stall = io_link_tx_valid & ~io_link_tx_ready;
            saved = {io_link_tx_bits, io_link_cnt, io_link_fmt_proto};
            if (io_link_tx_valid && io_link_tx_ready) begin
               got = '{io_link_tx_bits, io_link_cnt, io_link_fmt_proto, io_link_fmt_iodir, io_link_cs_clear};
               if (tx_q.size() == 0) begin
                  chk("tx_unexpected", 32'(got), 32'hFFFFFFFF);
               end else begin
                  e = tx_q.pop_front();
                  $display("tx %0d: bits=%h cnt=%0d proto=%0d iodir=%0d cs_clear=%0d (exp %h/%0d/%0d/%0d/%0d)",
                           tx_hs_cnt, got.bits, got.cnt, got.proto, got.iodir, got.csclr,
                           e.bits, e.cnt, e.proto, e.iodir, e.csclr);
                  chk("tx", 32'(got), 32'(e));
               end
               tx_hs_cnt++;
               if (!io_link_fmt_iodir) rx_cd = 2;
            end
            if (io_data_valid && io_data_ready) begin
               if (data_q.size() == 0) begin
                  chk("data_unexpected", {24'd0, io_data_bits}, 32'hFFFFFFFF);
               end else begin
                  d = data_q.pop_front();
                  $display("read: data=%h (exp %h)", io_data_bits, d);
                  chk("data", {24'd0, io_data_bits}, {24'd0, d});
               end
               data_done++;
            end
         end
         @(posedge clock);
         #1;
         io_link_rx_valid = 1'b0;
         if (reset) begin
            rx_cd = 0;
         end else if (rx_cd > 0) begin
            rx_cd--;
            if (rx_cd == 0) begin
               io_link_rx_valid = 1'b1;
               io_link_rx_bits = (rx_q.size() != 0) ? rx_q.pop_front() : 8'hEE;
            end
         end else if (inj_req != inj_seen) begin
            io_link_rx_valid = 1'b1;
            io_link_rx_bits = 8'h77;
            inj_seen++;
         end
         stall = 1'b0;
         if (io_link_tx_valid && tx_hs_cnt == stall_at && stall_n < 5) begin
            stall = 1'b1;
            stall_n++;
         end
         io_link_tx_ready = ~stall & ~(pad_block & io_link_tx_valid & (io_link_cnt != 8'd8));
      end
   end

   // Pushes the expected transfers for one request, then presents it until accepted.
   task automatic start_req(input logic [31:0] a, input logic merged,
                            input logic cen, input logic [7:0] code, input logic [1:0] cp,
                            input logic [2:0] alen, input logic [1:0] ap,
                            input logic [3:0] pcnt, input logic [7:0] pcode,
                            input logic [1:0] dp, input logic [7:0] rx);
      logic first;
      int   n;
      bit   ok;
      first = ~merged;
      if (!merged) begin
         if (cen) begin
            tx_q.push_back('{code, 8'd8, cp, 1'b1, first});
            first = 1'b0;
         end
         n = (alen > 3'd4) ? 4 : int'(alen);
         for (int i = n - 1; i >= 0; i--) begin
            tx_q.push_back('{8'(a >> (8 * i)), 8'd8, ap, 1'b1, first});
            first = 1'b0;
         end
         if (pcnt != 4'd0) begin
            tx_q.push_back('{pcode, {4'd0, pcnt}, ap, 1'b1, first});
            first = 1'b0;
         end
      end
      tx_q.push_back('{8'h00, 8'd8, dp, 1'b0, first});
      data_q.push_back(rx);
      rx_q.push_back(rx);
      io_insn_cmd_en = cen; io_insn_cmd_code = code; io_insn_cmd_proto = cp;
      io_insn_addr_len = alen; io_insn_addr_proto = ap; io_insn_pad_cnt = pcnt;
      io_insn_pad_code = pcode; io_insn_data_proto = dp;
      io_addr_bits = a;
      io_addr_valid = 1'b1;
      ok = 0;
      for (int c = 0; c < 50 && !ok; c++) begin
         @(negedge clock);
         if (io_addr_ready) ok = 1;
      end
      @(posedge clock); #1;
      io_addr_valid = 1'b0;
      if (!ok) chk("accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_done(input int target);
      bit ok;
      ok = 0;
      for (int c = 0; c < 300 && !ok; c++) begin
         @(negedge clock);
         if (data_done >= target) ok = 1;
      end
      @(posedge clock); #1;
      if (!ok) chk("done_timeout", 32'(data_done), 32'(target));
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_tx_valid"}, {31'd0, io_link_tx_valid}, 32'd0);
      chk({tag, "_tx_bits"}, {24'd0, io_link_tx_bits}, 32'd0);
      chk({tag, "_cnt"}, {24'd0, io_link_cnt}, 32'd0);
      chk({tag, "_proto"}, {30'd0, io_link_fmt_proto}, 32'd0);
      chk({tag, "_iodir"}, {31'd0, io_link_fmt_iodir}, 32'd0);
      chk({tag, "_cs_clear"}, {31'd0, io_link_cs_clear}, 32'd0);
      chk({tag, "_data_valid"}, {31'd0, io_data_valid}, 32'd0);
      chk({tag, "_data_bits"}, {24'd0, io_data_bits}, 32'd0);
   endtask

   int  nreq = 0;
   bit  ok_v;

   initial begin
      #23;
      chk_reset_outputs("reset");
      chk("reset_addr_ready", {31'd0, io_addr_ready}, 32'd0);
      chk("const_fmt", {29'd0, io_link_fmt_endian, io_link_cs_set, io_link_cs_hold}, 32'b011);
      @(posedge clock); #1;
      reset = 1'b0;
      io_en = 1'b1;
      @(posedge clock); #1;

      // Single read, second address byte stalled for 5 cycles.
      stall_at = 2;
      start_req(32'h00012345, 0, 1, 8'h03, 2'd0, 3'd3, 2'd0, 4'd0, 8'h00, 2'd0, 8'hA5);
      wait_done(++nreq);

      // Stray rx pulses in IDLE must not produce a response.
      inj_req++;
      repeat (3) @(posedge clock);
      inj_req++;
      repeat (3) @(posedge clock);
      #1;
      chk("idle_rx_no_valid", {31'd0, io_data_valid}, 32'd0);
      chk("idle_rx_ready", {31'd0, io_addr_ready}, 32'd1);

      // Sequential follow-up merges; a jump restarts.
      start_req(32'h00012346, 1, 1, 8'h03, 2'd0, 3'd3, 2'd0, 4'd0, 8'h00, 2'd0, 8'h5A);
      wait_done(++nreq);
      start_req(32'h00020000, 0, 1, 8'h03, 2'd0, 3'd3, 2'd0, 4'd0, 8'h00, 2'd0, 8'h3C);
      wait_done(++nreq);

      // Quad fast read.
      start_req(32'h00ABCDEF, 0, 1, 8'hEB, 2'd0, 3'd3, 2'd2, 4'd6, 8'hFF, 2'd2, 8'h81);
      wait_done(++nreq);

      // Merged read with consumer stalled, io_en dropped at the handshake.
      io_data_ready = 1'b0;
      start_req(32'h00ABCDF0, 1, 1, 8'hEB, 2'd0, 3'd3, 2'd2, 4'd6, 8'hFF, 2'd2, 8'h42);
      ok_v = 0;
      for (int c = 0; c < 50 && !ok_v; c++) begin
         @(negedge clock);
         if (io_data_valid) ok_v = 1;
      end
      if (!ok_v) chk("resp_timeout", 32'd0, 32'd1);
      for (int c = 0; c < 10; c++) begin
         @(negedge clock);
         chk("resp_hold_valid", {31'd0, io_data_valid}, 32'd1);
         chk("resp_hold_ready", {31'd0, io_addr_ready}, 32'd0);
      end
      @(posedge clock); #1;
      io_en = 1'b0;
      io_data_ready = 1'b1;
      @(posedge clock); #1;
      io_en = 1'b1;
      wait_done(++nreq);
      start_req(32'h00ABCDF1, 0, 1, 8'hEB, 2'd0, 3'd3, 2'd2, 4'd6, 8'hFF, 2'd2, 8'h17);
      wait_done(++nreq);

      // Reset while the pad transfer is presented.
      pad_block = 1'b1;
      start_req(32'h00001000, 0, 1, 8'hEB, 2'd0, 3'd3, 2'd2, 4'd6, 8'hFF, 2'd2, 8'h99);
      ok_v = 0;
      for (int c = 0; c < 50 && !ok_v; c++) begin
         @(negedge clock);
         if (io_link_tx_valid && io_link_cnt == 8'd6 && !io_link_tx_ready) ok_v = 1;
      end
      if (!ok_v) chk("pad_timeout", 32'd0, 32'd1);
      #1;
      reset = 1'b1;
      #1;
      chk_reset_outputs("midreset");
      tx_q.delete();
      data_q.delete();
      rx_q.delete();
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
      pad_block = 1'b0;
      data_done = data_done;
      @(posedge clock); #1;

      // Fresh full sequence after reset; no cmd, address length 7 clamps to 4 bytes.
      start_req(32'h00001001, 0, 0, 8'h00, 2'd0, 3'd7, 2'd1, 4'd0, 8'h00, 2'd1, 8'hC3);
      wait_done(++nreq);

      repeat (3) @(posedge clock);
      chk("tx_queue_empty", 32'(tx_q.size()), 32'd0);
      chk("data_queue_empty", 32'(data_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
